// File: rtl/rmii_rx_byte_assembler.sv
// RMII receive deserializer: finds preamble/SFD, detects 10/100 speed,
// packs dibits LSB-first into bytes. Out: speed_code, packaged_data[8:0], strobe.
module rmii_rx_byte_assembler #(
  parameter int unsigned SPEED_THRESHOLD       = 64,
  parameter int unsigned SAMPLES_PER_DIBIT_10M = 10
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] data,
  input  logic       data_enable,
  input  logic       data_error,
  output logic [1:0] speed_code,
  output logic [8:0] packaged_data,
  output logic       packaged_data_valid
);

  typedef enum logic [1:0] {
    IDLE,
    PREAMBLE,
    DATA,
    DRAIN
  } state_e;

  // First 10M sample lands mid-dibit of the first data dibit,
  // counted from the SFD onset cycle.
  localparam int unsigned FIRST_OFF =
    SAMPLES_PER_DIBIT_10M + SAMPLES_PER_DIBIT_10M / 2 - 1;
  localparam int unsigned PW = $clog2(FIRST_OFF + 1);

  localparam logic [PW-1:0] FIRST_LD = PW'(FIRST_OFF);
  localparam logic [PW-1:0] NEXT_LD  = PW'(SAMPLES_PER_DIBIT_10M - 1);
  localparam logic [PW-1:0] PH_ONE   = PW'(1);
  localparam logic [15:0]   THR      = 16'(SPEED_THRESHOLD);
  localparam logic [1:0]    SPD_100  = 2'b01;
  localparam logic [1:0]    SPD_10   = 2'b00;

  state_e        state_q, state_d;
  logic [15:0]   pre_q, pre_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [1:0]    dcnt_q, dcnt_d;
  logic [7:0]    byte_q, byte_d;
  logic          first_q, first_d;
  logic [1:0]    speed_q, speed_d;
  logic [8:0]    pd_q, pd_d;
  logic          vld_q, vld_d;

  logic [15:0] pre_inc;
  logic        is_10m;
  logic        data_ok;
  logic [7:0]  shifted;

  // Increment includes the SFD cycle, so the compared value is the
  // number of 01 cycles seen.
  assign pre_inc = (pre_q == 16'hFFFF) ? pre_q : pre_q + 16'd1;
  assign is_10m  = (pre_inc >= THR);
  assign data_ok = data_enable && !data_error;
  assign shifted = {data, byte_q[7:2]};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pre_q   <= '0;
      phase_q <= '0;
      dcnt_q  <= '0;
      byte_q  <= '0;
      first_q <= 1'b0;
      speed_q <= SPD_100;
      pd_q    <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      phase_q <= phase_d;
      dcnt_q  <= dcnt_d;
      byte_q  <= byte_d;
      first_q <= first_d;
      speed_q <= speed_d;
      pd_q    <= pd_d;
      vld_q   <= vld_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (data_enable && data == 2'b01)
          state_d = PREAMBLE;
      end
      PREAMBLE: begin
        if (!data_enable) begin
          state_d = IDLE;
        end else if (data_error) begin
          state_d = DRAIN;
        end else begin
          unique case (1'b1)
            (data == 2'b01): state_d = PREAMBLE;
            (data == 2'b11): state_d = DATA;
            default:         state_d = IDLE;
          endcase
        end
      end
      DATA: begin
        if (!data_enable)
          state_d = IDLE;
        else if (data_error)
          state_d = DRAIN;
      end
      DRAIN: begin
        if (!data_enable)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pre_d   = pre_q;
    phase_d = phase_q;
    dcnt_d  = dcnt_q;
    byte_d  = byte_q;
    first_d = first_q;
    speed_d = speed_q;
    pd_d    = pd_q;
    vld_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (data_enable && data == 2'b01)
          pre_d = '0;
      end
      PREAMBLE: begin
        pre_d = pre_inc;
        if (data_ok && data == 2'b11) begin
          speed_d = is_10m ? SPD_10 : SPD_100;
          phase_d = is_10m ? FIRST_LD : '0;
          first_d = 1'b1;
          byte_d  = '0;
          dcnt_d  = '0;
        end
      end
      DATA: begin
        if (!data_ok) begin
          byte_d = '0;
          dcnt_d = '0;
        end else if (phase_q != '0) begin
          phase_d = phase_q - PH_ONE;
        end else begin
          phase_d = (speed_q == SPD_10) ? NEXT_LD : '0;
          byte_d  = shifted;
          dcnt_d  = dcnt_q + 2'd1;
          if (dcnt_q == 2'd3) begin
            vld_d   = 1'b1;
            pd_d    = {first_q, shifted};
            first_d = 1'b0;
          end
        end
      end
      DRAIN: begin
        byte_d = '0;
        dcnt_d = '0;
      end
      default: ;
    endcase
  end

  assign speed_code          = speed_q;
  assign packaged_data       = pd_q;
  assign packaged_data_valid = vld_q;

endmodule

// File: tb/tb_rmii_rx_byte_assembler.sv
// Bench for rmii_rx_byte_assembler: directed and random frames checked
// against an arithmetic timing/content model of the receive stream.
module tb_rmii_rx_byte_assembler;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [1:0] data;
  logic       data_enable;
  logic       data_error;
  logic [1:0] speed_code;
  logic [8:0] packaged_data;
  logic       packaged_data_valid;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_edge = 0;

  int obs_w[$];
  int obs_e[$];
  int exp_w[$];
  int exp_e[$];
  logic [7:0] frame_bytes[$];
  logic [1:0] mdl_speed;

  rmii_rx_byte_assembler dut (
    .clock               (clock),
    .reset_n             (reset_n),
    .data                (data),
    .data_enable         (data_enable),
    .data_error          (data_error),
    .speed_code          (speed_code),
    .packaged_data       (packaged_data),
    .packaged_data_valid (packaged_data_valid)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock) begin
    #1;
    if (packaged_data_valid === 1'b1) begin
      obs_w.push_back(int'(packaged_data));
      obs_e.push_back(cyc - 1);
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", tag, got, want);
    end
  endtask

  task automatic drive(input logic de, input logic [1:0] d,
                       input logic er);
    @(negedge clock);
    data_enable = de;
    data        = d;
    data_error  = er;
    last_edge   = cyc;
  endtask

  task automatic hold(input logic de, input logic [1:0] d,
                      input logic er, input int n);
    for (int i = 0; i < n; i++) drive(de, d, er);
  endtask

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++)
      drive(1'b0, 2'($urandom), 1'($urandom));
  endtask

  task automatic clear_obs();
    obs_w.delete();
    obs_e.delete();
    exp_w.delete();
    exp_e.delete();
  endtask

  task automatic compare(input string tag);
    int n;
    chk({tag, "_count"}, obs_w.size(), exp_w.size());
    n = (obs_w.size() < exp_w.size()) ? obs_w.size() : exp_w.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_word"}, obs_w[i], exp_w[i]);
      chk({tag, "_cycle"}, obs_e[i], exp_e[i]);
    end
    chk({tag, "_speed"}, speed_code, mdl_speed);
    chk({tag, "_idle_valid"}, packaged_data_valid, 0);
    if (exp_w.size() > 0)
      chk({tag, "_hold"}, packaged_data, exp_w[exp_w.size()-1]);
  endtask

  // h: cycles per dibit; npre: number of 01 dibits; extra: trailing
  // partial dibits; err_at: data dibit index carrying RX_ER, or -1.
  task automatic run_frame(input int h, input int npre, input int extra,
                           input int err_at, input string tag);
    logic [1:0] dibs[$];
    logic [7:0] b;
    int s;
    int end_e;
    int se;
    clear_obs();
    foreach (frame_bytes[k]) begin
      b = frame_bytes[k];
      for (int j = 0; j < 4; j++) dibs.push_back(b[2*j +: 2]);
    end
    for (int j = 0; j < extra; j++) dibs.push_back(2'($urandom));
    hold(1'b1, 2'b01, 1'b0, npre * h);
    drive(1'b1, 2'b11, 1'b0);
    s = last_edge;
    hold(1'b1, 2'b11, 1'b0, h - 1);
    mdl_speed = (npre * h >= 64) ? 2'b00 : 2'b01;
    end_e = -1;
    foreach (dibs[j]) begin
      if (j == err_at) begin
        drive(1'b1, dibs[j], 1'b1);
        end_e = last_edge;
        hold(1'b1, dibs[j], 1'b0, h - 1);
      end else begin
        hold(1'b1, dibs[j], 1'b0, h);
      end
    end
    drive(1'b0, 2'b00, 1'b0);
    if (end_e < 0) end_e = last_edge;
    idle_gap(6 + $urandom_range(0, 6));
    // Dibit j is sampled at s+1+j (100M) or s+15+10j (10M); a byte
    // appears iff its last dibit is sampled before the frame ends.
    foreach (frame_bytes[k]) begin
      se = s + ((mdl_speed == 2'b00) ? 15 + 10 * (4 * k + 3)
                                     : 1 + (4 * k + 3));
      if (se < end_e) begin
        exp_w.push_back((k == 0 ? 256 : 0) + int'(frame_bytes[k]));
        exp_e.push_back(se);
      end
    end
    compare(tag);
  endtask

  initial begin
    int h;
    int npre;
    int nb;
    int extra;
    int total;
    int err_at;

    reset_n     = 1'b0;
    data        = 2'b00;
    data_enable = 1'b0;
    data_error  = 1'b0;
    mdl_speed   = 2'b01;
    repeat (3) @(negedge clock);
    chk("rst_valid", packaged_data_valid, 0);
    chk("rst_data", packaged_data, 0);
    chk("rst_speed", speed_code, 2'b01);
    reset_n = 1'b1;
    idle_gap(4);

    frame_bytes = '{8'hFF, 8'h12, 8'hAB};
    run_frame(1, 31, 0, -1, "f100");

    run_frame(10, 31, 0, -1, "f10");

    frame_bytes = '{8'h34};
    run_frame(1, 31, 2, -1, "partial");

    frame_bytes = '{8'hC3, 8'h5E, 8'h77};
    run_frame(1, 20, 0, 6, "error");
    frame_bytes = '{8'h81, 8'h42};
    run_frame(1, 15, 0, -1, "post_err");

    clear_obs();
    drive(1'b1, 2'b01, 1'b0);
    drive(1'b1, 2'b01, 1'b0);
    drive(1'b1, 2'b10, 1'b0);
    drive(1'b1, 2'b00, 1'b0);
    idle_gap(5);
    compare("badpre");

    frame_bytes = '{};
    run_frame(1, 63, 0, -1, "thr63");
    run_frame(1, 64, 0, -1, "thr64");
    run_frame(1, 65, 0, -1, "thr65");
    run_frame(1, 10, 0, -1, "thr10");

    clear_obs();
    hold(1'b1, 2'b01, 1'b0, 80);
    hold(1'b1, 2'b11, 1'b0, 10);
    hold(1'b1, 2'b10, 1'b0, 10);
    hold(1'b1, 2'b10, 1'b0, 10);
    hold(1'b1, 2'b01, 1'b0, 10);
    hold(1'b1, 2'b01, 1'b0, 10);
    hold(1'b1, 2'b10, 1'b0, 10);
    chk("mid_speed", speed_code, 2'b00);
    chk("mid_data", packaged_data, 9'h15A);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_valid", packaged_data_valid, 0);
    chk("arst_data", packaged_data, 0);
    chk("arst_speed", speed_code, 2'b01);
    mdl_speed = 2'b01;
    idle_gap(3);
    reset_n = 1'b1;
    idle_gap(3);
    frame_bytes = '{8'hE7, 8'h09};
    run_frame(1, 12, 0, -1, "post_rst");

    for (int f = 0; f < 20; f++) begin
      h = ($urandom_range(0, 1) == 1) ? 10 : 1;
      npre = (h == 1) ? $urandom_range(2, 40) : $urandom_range(7, 20);
      nb = $urandom_range(0, 5);
      extra = $urandom_range(0, 3);
      frame_bytes = '{};
      for (int k = 0; k < nb; k++)
        frame_bytes.push_back(8'($urandom));
      total = 4 * nb + extra;
      err_at = -1;
      if (total > 0 && $urandom_range(0, 3) == 0)
        err_at = $urandom_range(0, total - 1);
      run_frame(h, npre, extra, err_at, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rmii_rx_byte_assembler.md
Name: rmii_rx_byte_assembler

Overview:
Receive-side RMII deserializer. It hunts for the Ethernet preamble/SFD on a 2-bit RMII receive stream and detects line speed (10 or 100 Mbps). It then packs dibits LSB-first into bytes and emits a 9-bit word per byte: bit 8 flags the first byte of a frame. It sits between an RMII PHY receive interface (or a switch's RMII transmit output under test) and byte-oriented frame logic.

Parameters:
SPEED_THRESHOLD, 64, preamble length in clock cycles (first 01 dibit to SFD 11 dibit) at or above which the link is classified 10 Mbps.
SAMPLES_PER_DIBIT_10M, 10, clock cycles per dibit in 10 Mbps mode.

Ports:
clock  input  1  system clock; one RMII dibit per cycle at 100 Mbps.
reset_n  input  1  asynchronous active-low reset.
data  input  2  RMII receive dibit; data[0] is the earlier bit.
data_enable  input  1  CRS_DV; high while frame dibits are present.
data_error  input  1  RX_ER; abort the current frame.
speed_code  output  2  2'b01 = 100 Mbps, 2'b00 = 10 Mbps; reflects the last SFD detection.
packaged_data  output  9  [7:0] received byte; [8] = 1 on the first byte after the SFD.
packaged_data_valid  output  1  one-cycle strobe qualifying packaged_data.

Behaviour:
- Clock and reset: single clock, reset asynchronous active-low (reset_n).
- Reset values:
  - packaged_data = 0, packaged_data_valid = 0, speed_code = 2'b01.
  - State = IDLE; all counters and the shift register cleared.
- States: IDLE, PREAMBLE, DATA, DRAIN.
- IDLE:
  - Stay while data_enable = 0 or data = 2'b00.
  - On data_enable = 1 and data = 2'b01: go to PREAMBLE and clear the preamble counter.
- PREAMBLE:
  - The counter increments each cycle (saturating at 16 bits).
  - data = 2'b01: stay.
  - data = 2'b11: SFD is found.
    - Latch speed_code = 2'b00 if counter >= SPEED_THRESHOLD, else 2'b01.
    - Go to DATA with the byte-first flag set.
  - data = 2'b00 or 2'b10, or data_enable falling: go to IDLE with no output.
- DATA, 100 Mbps: one dibit is sampled every cycle.
- DATA, 10 Mbps sampling:
  - Sampling phase is anchored at the SFD 11 dibit onset: the first data dibit is sampled 15 cycles after that onset.
  - Subsequent dibits are sampled every SAMPLES_PER_DIBIT_10M cycles.
- Packing:
  - Each sampled dibit shifts into the byte register: byte = {dibit, byte[7:2]}.
  - The 1st dibit lands in bits [1:0] and the 4th in [7:6].
- Output:
  - The cycle after the 4th dibit is sampled: packaged_data_valid = 1 for exactly 1 cycle, with packaged_data = {first_flag, byte}.
  - first_flag then clears; the dibit counter wraps to 0.
- Frame end:
  - data_enable low in DATA: go to IDLE.
  - A partial byte (1–3 dibits) is discarded with no strobe; any strobe already scheduled still fires.
- Error handling:
  - data_error = 1 in PREAMBLE or DATA: discard the partial byte, suppress output, go to DRAIN.
  - DRAIN: go to IDLE when data_enable = 0.
- data_error in IDLE is ignored.
- packaged_data holds its last value between strobes.
- speed_code changes only at SFD detection.
- Reset mid-frame: all outputs return to their reset values immediately, regardless of the clock.
- A new frame requires data_enable to be low for at least 1 cycle.

Test Plan:
1. 100 Mbps: data_enable high, 31×2'b01 then 2'b11, then the dibits of bytes 0xFF,0x12,0xAB → three strobes: 0x1FF, 0x012, 0x0AB; speed_code = 2'b01.
2. 10 Mbps: the same frame with every dibit held 10 cycles → the same three words, strobes 40 cycles apart; speed_code = 2'b00.
3. Partial byte: after the SFD, send 0x34 plus 2 extra dibits, then drop data_enable → a single strobe 0x134, no further valid; state = IDLE.
4. Error: data_error pulsed after 2 dibits of byte 2 → only byte 1 output; no strobes until data_enable low, then a new frame is accepted normally.
5. Bad preamble: 01,01,10 → no SFD, no strobe; speed_code unchanged.
6. Reset mid-frame: assert reset_n = 0 during DATA → valid = 0, data = 0, speed_code = 2'b01 immediately; after release, the next frame works.
